// File: rtl/decode_inst_buffer.sv
`default_nettype none
// ============================================================================
// Module      : decode_inst_buffer
// Description : Instruction buffer between decode and rename. It takes up to
//               IN_SLOTS decoded packets per cycle, with one valid bit per
//               slot. Valid slots are compacted in program order into a
//               circular queue. Fixed bundles of OUT_WIDTH packets are then
//               presented to rename.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk               rising-edge clock
//   reset             synchronous active-high reset
//   flush_i           pipeline recovery, empties the buffer on the next edge
//   decodeReady_i     a decode group is present this cycle
//   ibValid_i         per-slot packet valid
//   ibPacket_i        slot k occupies bits [k*PKT_W +: PKT_W]
//   renameReady_i     rename consumes the presented bundle this cycle
//   stall_o           backpressure toward fetch/decode
//   instBufferReady_o a full bundle is presented on renPacket_o
//   renPacket_o       bundle, lane 0 is the oldest packet
//   occupancy_o       number of valid entries currently held
// ============================================================================
module decode_inst_buffer #(
   parameter int IN_SLOTS  = 8,
   parameter int OUT_WIDTH = 4,
   parameter int DEPTH     = 32,
   parameter int PKT_W     = 128,
   parameter int CNT_W     = 6
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush_i,
   input  logic                          decodeReady_i,
   input  logic [IN_SLOTS-1:0]           ibValid_i,
   input  logic [IN_SLOTS*PKT_W-1:0]     ibPacket_i,
   input  logic                          renameReady_i,
   output logic                          stall_o,
   output logic                          instBufferReady_o,
   output logic [OUT_WIDTH*PKT_W-1:0]    renPacket_o,
   output logic [CNT_W-1:0]              occupancy_o
);

   localparam int               PTR_W     = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] SLOT_CNT  = CNT_W'(IN_SLOTS);
   localparam logic [CNT_W-1:0] OUT_CNT   = CNT_W'(OUT_WIDTH);
   localparam logic [PTR_W-1:0] OUT_PTR   = PTR_W'(OUT_WIDTH);

   logic [PKT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   logic             wr_en;
   logic             rd_en;
   logic [CNT_W-1:0] valid_sum;
   logic [CNT_W-1:0] nwr;
   logic [CNT_W-1:0] rd_sub;
   logic [PTR_W-1:0] wr_idx [IN_SLOTS];

   // Backpressure depends on registered occupancy only. A read in the same
   // cycle does not relax it, so a full group always fits and no input
   // reaches an output through combinational logic.
   assign stall_o           = (DEPTH_CNT - count) < SLOT_CNT;
   assign instBufferReady_o = count >= OUT_CNT;
   assign occupancy_o       = count;

   assign wr_en  = decodeReady_i & ~stall_o & ~flush_i;
   assign rd_en  = instBufferReady_o & renameReady_i & ~flush_i;
   assign nwr    = wr_en ? valid_sum : '0;
   assign rd_sub = rd_en ? OUT_CNT : '0;

   // Compaction. A valid slot is written at tail plus the number of valid
   // slots below it, so invalid slots take no entry and program order holds.
   // The pointer-width sum wraps modulo DEPTH by itself.
   always_comb begin
      valid_sum = '0;
      for (int k = 0; k < IN_SLOTS; k++) begin
         wr_idx[k] = tail + valid_sum[PTR_W-1:0];
         valid_sum = valid_sum + CNT_W'(ibValid_i[k]);
      end
   end

   // Storage needs no reset. The pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < IN_SLOTS; k++) begin
            if (ibValid_i[k]) begin
               mem[wr_idx[k]] <= ibPacket_i[k*PKT_W +: PKT_W];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         tail  <= tail + nwr[PTR_W-1:0];
         if (rd_en) begin
            head <= head + OUT_PTR;
         end
         count <= count + nwr - rd_sub;
      end
   end

   // Bundles are all-or-nothing. The output is held at zero until a full
   // bundle is available.
   generate
      for (genvar i = 0; i < OUT_WIDTH; i++) begin : g_lane
         logic [PTR_W-1:0] rd_idx;
         assign rd_idx = head + PTR_W'(i);
         assign renPacket_o[i*PKT_W +: PKT_W] = instBufferReady_o ? mem[rd_idx] : '0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_decode_inst_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_inst_buffer
// Description : Self-checking bench for decode_inst_buffer. It runs a table
//               of directed vectors, hand-written corner sequences and a
//               randomized run. All of these are checked against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_inst_buffer;

   localparam int NS = 8;
   localparam int NO = 4;
   localparam int DP = 32;
   localparam int PW = 128;
   localparam int CW = 6;

   logic               clk = 1'b0;
   logic               reset;
   logic               flush_i;
   logic               decodeReady_i;
   logic [NS-1:0]      ibValid_i;
   logic [NS*PW-1:0]   ibPacket_i;
   logic               renameReady_i;
   logic               stall_o;
   logic               instBufferReady_o;
   logic [NO*PW-1:0]   renPacket_o;
   logic [CW-1:0]      occupancy_o;

   int total = 0;
   int bad   = 0;
   int proto = 0;

   logic [PW-1:0] mq[$];

   decode_inst_buffer #(
      .IN_SLOTS (NS),
      .OUT_WIDTH(NO),
      .DEPTH    (DP),
      .PKT_W    (PW),
      .CNT_W    (CW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .flush_i          (flush_i),
      .decodeReady_i    (decodeReady_i),
      .ibValid_i        (ibValid_i),
      .ibPacket_i       (ibPacket_i),
      .renameReady_i    (renameReady_i),
      .stall_o          (stall_o),
      .instBufferReady_o(instBufferReady_o),
      .renPacket_o      (renPacket_o),
      .occupancy_o      (occupancy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       dec;
      logic [7:0] val;
      logic       ren;
      logic       fl;
      logic       rs;
      int         occ;
      logic       rdy;
      logic       stl;
   } vec_t;

   vec_t tbl[17];

   function automatic logic [PW-1:0] mkpkt(input int g, input int k);
      return {32'(g), 32'(k), 32'hDEAD_BEEF, 32'(g * 16 + k)};
   endfunction

   function automatic logic [NS*PW-1:0] mkgroup(input int g);
      logic [NS*PW-1:0] p;
      for (int k = 0; k < NS; k++) p[k*PW +: PW] = mkpkt(g, k);
      return p;
   endfunction

   task automatic chk(input string nm, input logic [NO*PW-1:0] act, input logic [NO*PW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [NO*PW-1:0] model_bundle();
      logic [NO*PW-1:0] e;
      e = '0;
      if (mq.size() >= NO)
         for (int i = 0; i < NO; i++) e[i*PW +: PW] = mq[i];
      return e;
   endfunction

   // One clock. The inputs are driven at the falling edge. The model steps
   // on the rising edge. Outputs are compared against the model 1 time unit
   // later.
   task automatic step(input logic d, input logic [NS-1:0] v, input logic [NS*PW-1:0] p,
                       input logic r, input logic f, input logic rs);
      logic stl;
      logic rdy;
      @(negedge clk);
      decodeReady_i = d;
      ibValid_i     = v;
      ibPacket_i    = p;
      renameReady_i = r;
      flush_i       = f;
      reset         = rs;
      stl = (DP - mq.size()) < NS;
      rdy = mq.size() >= NO;
      if (d && stl && !rs && !f) begin
         proto++;
         $display("note: protocol error, decodeReady_i while stalled (input ignored)");
      end
      @(posedge clk);
      if (rs || f) begin
         mq.delete();
      end else begin
         if (rdy && r) repeat (NO) void'(mq.pop_front());
         if (d && !stl)
            for (int k = 0; k < NS; k++)
               if (v[k]) mq.push_back(p[k*PW +: PW]);
      end
      #1;
      chk("model_occupancy", (NO*PW)'(occupancy_o), (NO*PW)'(mq.size()));
      chk("model_ready",     (NO*PW)'(instBufferReady_o), (NO*PW)'(mq.size() >= NO));
      chk("model_stall",     (NO*PW)'(stall_o), (NO*PW)'((DP - mq.size()) < NS));
      chk("model_bundle",    renPacket_o, model_bundle());
   endtask

   initial begin
      logic [NO*PW-1:0] exp_b;
      logic [NS*PW-1:0] grp;
      logic             d;
      logic [NS*PW-1:0] rp;

      reset = 1'b1; flush_i = 1'b0; decodeReady_i = 1'b0; ibValid_i = '0;
      ibPacket_i = '0; renameReady_i = 1'b0;

      //          dec   val       ren   fl    rs    occ rdy   stl
      tbl[0]  = '{1'b0, 8'h00,    1'b0, 1'b0, 1'b1, 0,  1'b0, 1'b0};
      tbl[1]  = '{1'b1, 8'b1011_0101, 1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 8'h00,    1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b0};
      tbl[3]  = '{1'b0, 8'h00,    1'b0, 1'b0, 1'b1, 0,  1'b0, 1'b0};
      tbl[4]  = '{1'b1, 8'hFF,    1'b0, 1'b0, 1'b0, 8,  1'b1, 1'b0};
      tbl[5]  = '{1'b1, 8'hFF,    1'b0, 1'b0, 1'b0, 16, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 8'hFF,    1'b0, 1'b0, 1'b0, 24, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 8'hFF,    1'b0, 1'b0, 1'b0, 32, 1'b1, 1'b1};
      tbl[8]  = '{1'b1, 8'hFF,    1'b0, 1'b0, 1'b0, 32, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 8'h00,    1'b1, 1'b0, 1'b0, 28, 1'b1, 1'b1};
      tbl[10] = '{1'b0, 8'h00,    1'b1, 1'b0, 1'b0, 24, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 8'h00,    1'b1, 1'b0, 1'b0, 20, 1'b1, 1'b0};
      tbl[12] = '{1'b1, 8'hFF,    1'b1, 1'b1, 1'b0, 0,  1'b0, 1'b0};
      tbl[13] = '{1'b1, 8'hFF,    1'b0, 1'b0, 1'b0, 8,  1'b1, 1'b0};
      tbl[14] = '{1'b1, 8'hFF,    1'b0, 1'b0, 1'b0, 16, 1'b1, 1'b0};
      tbl[15] = '{1'b1, 8'h01,    1'b0, 1'b0, 1'b0, 17, 1'b1, 1'b0};
      tbl[16] = '{1'b1, 8'hFF,    1'b1, 1'b0, 1'b1, 0,  1'b0, 1'b0};

      for (int i = 0; i < 17; i++) begin
         step(tbl[i].dec, tbl[i].val, mkgroup(i), tbl[i].ren, tbl[i].fl, tbl[i].rs);
         chk($sformatf("tbl%0d_occ", i), (NO*PW)'(occupancy_o), (NO*PW)'(tbl[i].occ));
         chk($sformatf("tbl%0d_rdy", i), (NO*PW)'(instBufferReady_o), (NO*PW)'(tbl[i].rdy));
         chk($sformatf("tbl%0d_stl", i), (NO*PW)'(stall_o), (NO*PW)'(tbl[i].stl));
         if (i == 1) begin
            exp_b = {mkpkt(1, 5), mkpkt(1, 4), mkpkt(1, 2), mkpkt(1, 0)};
            chk("tbl1_bundle", renPacket_o, exp_b);
         end
         if (i == 2) chk("tbl2_bundle_zero", renPacket_o, '0);
      end

      // Count of 12, then a write of 8 and a read of 4 in the same cycle.
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'hFF, mkgroup(50), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h0F, mkgroup(51), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'hFF, mkgroup(52), 1'b1, 1'b0, 1'b0);
      chk("rw_occ16", (NO*PW)'(occupancy_o), (NO*PW)'(16));
      exp_b = {mkpkt(50, 7), mkpkt(50, 6), mkpkt(50, 5), mkpkt(50, 4)};
      chk("rw_oldest", renPacket_o, exp_b);
      repeat (4) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

      // Wrap-around: bring head and tail to 28, then write 8 across index 0.
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      for (int g = 0; g < 3; g++) step(1'b1, 8'hFF, mkgroup(60 + g), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h0F, mkgroup(63), 1'b0, 1'b0, 1'b0);
      repeat (7) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      chk("wrap_empty", (NO*PW)'(occupancy_o), '0);
      grp = mkgroup(100);
      step(1'b1, 8'hFF, grp, 1'b0, 1'b0, 1'b0);
      chk("wrap_bundle0", renPacket_o, grp[NO*PW-1:0]);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      chk("wrap_bundle1", renPacket_o, grp[NS*PW-1:NO*PW]);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      chk("wrap_drained", (NO*PW)'(occupancy_o), '0);

      // Randomized traffic against the queue model.
      for (int n = 0; n < 600; n++) begin
         d = ($urandom_range(3) != 0);
         if (((DP - mq.size()) < NS) && ($urandom_range(7) != 0)) d = 1'b0;
         for (int k = 0; k < NS; k++) rp[k*PW +: PW] = {$urandom, $urandom, $urandom, $urandom};
         step(d, NS'($urandom), rp, ($urandom_range(9) < 4), ($urandom_range(49) == 0),
              ($urandom_range(99) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
